// File: rtl/led_flow_pkg.sv
// Shared mode encodings and key roles for the LED flow controller.
// Types and constants only; no latency, no backpressure.
package led_flow_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'd0,
    MODE_SHL  = 2'd1,
    MODE_SHR  = 2'd2,
    MODE_PING = 2'd3
  } mode_e;

  localparam int NUM_KEYS  = 4;
  localparam int KEY_SHL   = 0;
  localparam int KEY_SHR   = 1;
  localparam int KEY_PING  = 2;
  localparam int KEY_PAUSE = 3;

  // Lowest key index wins when several mode keys fire together.
  function automatic mode_e key_to_mode(input logic [2:0] hit);
    mode_e m;
    m = MODE_IDLE;
    if (hit[KEY_SHL])       m = MODE_SHL;
    else if (hit[KEY_SHR])  m = MODE_SHR;
    else if (hit[KEY_PING]) m = MODE_PING;
    return m;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF sync, DEB_CNT-sample debounce, one-cycle press pulse on accepted 1->0.
// Latency 2 + DEB_CNT cycles from key edge to press; no backpressure.
module key_debounce #(
  parameter int DEB_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Reset state is "released": all key levels high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_flow_ctrl.sv
// LED running-light controller: debounced keys select SHL/SHR/PING patterns stepped every STEP_CNT cycles.
// Mode loads one cycle after the press pulse; no backpressure. Optional pause on key[3] via LED_FLOW_PAUSE_EN.
module led_flow_ctrl
  import led_flow_pkg::*;
#(
  parameter int LED_W    = 4,
  parameter int STEP_CNT = 25_000_000,
  parameter int DEB_CNT  = 1_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       key,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode
);

  localparam int SW = (STEP_CNT > 1) ? $clog2(STEP_CNT) : 1;
  localparam logic [SW-1:0]    STEP_LAST = SW'(STEP_CNT - 1);
  localparam logic [LED_W-1:0] PAT_LO    = LED_W'(1);
  localparam logic [LED_W-1:0] PAT_HI    = PAT_LO << (LED_W - 1);

  logic [NUM_KEYS-1:0] press;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (key[i]),
      .press (press[i])
    );
  end

  mode_e            state;
  logic             dir_up;
  logic [SW-1:0]    step;
  logic [LED_W-1:0] pat;
  logic [LED_W-1:0] nxt_pat;
  logic             nxt_dir;
  logic             mode_hit;
  mode_e            mode_sel;
  logic [LED_W-1:0] start_pat;
  logic             run;

  assign led  = pat;
  assign mode = state;

  function automatic logic [LED_W-1:0] rot_up(input logic [LED_W-1:0] v);
    logic [LED_W-1:0] r;
    r = '0;
    for (int i = 0; i < LED_W; i++) r[(i + 1) % LED_W] = v[i];
    return r;
  endfunction

  function automatic logic [LED_W-1:0] rot_dn(input logic [LED_W-1:0] v);
    logic [LED_W-1:0] r;
    r = '0;
    for (int i = 0; i < LED_W; i++) r[i] = v[(i + 1) % LED_W];
    return r;
  endfunction

  always_comb begin
    mode_hit  = |press[KEY_PING:KEY_SHL];
    mode_sel  = key_to_mode(press[KEY_PING:KEY_SHL]);
    start_pat = (mode_sel == MODE_SHR) ? PAT_HI : PAT_LO;
  end

  // PING bounces off the end bits so they are shown once per sweep.
  always_comb begin
    nxt_pat = pat;
    nxt_dir = dir_up;
    if (LED_W == 1) begin
      nxt_pat = '1;
    end else begin
      case (state)
        MODE_SHL: nxt_pat = rot_up(pat);
        MODE_SHR: nxt_pat = rot_dn(pat);
        MODE_PING: begin
          if (dir_up) begin
            if (pat[LED_W-1]) begin
              nxt_pat = pat >> 1;
              nxt_dir = 1'b0;
            end else begin
              nxt_pat = pat << 1;
            end
          end else begin
            if (pat[0]) begin
              nxt_pat = pat << 1;
              nxt_dir = 1'b1;
            end else begin
              nxt_pat = pat >> 1;
            end
          end
        end
        default: nxt_pat = '0;
      endcase
    end
  end

`ifdef LED_FLOW_PAUSE_EN
  logic pause;
  logic pause_hit;

  // The toggle cycle itself never advances the counter, so a freeze is exact.
  assign pause_hit = press[KEY_PAUSE] && (state != MODE_IDLE);
  assign run       = (state != MODE_IDLE) && !pause && !pause_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause <= 1'b0;
    end else if (mode_hit) begin
      pause <= 1'b0;
    end else if (pause_hit) begin
      pause <= ~pause;
    end
  end
`else
  logic unused_pause_key;

  assign unused_pause_key = press[KEY_PAUSE];
  assign run              = (state != MODE_IDLE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MODE_IDLE;
      pat    <= '0;
      step   <= '0;
      dir_up <= 1'b1;
    end else if (mode_hit) begin
      state  <= mode_sel;
      pat    <= start_pat;
      step   <= '0;
      dir_up <= 1'b1;
    end else if (run) begin
      if (step == STEP_LAST) begin
        step   <= '0;
        pat    <= nxt_pat;
        dir_up <= nxt_dir;
      end else begin
        step <= step + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl at LED_W=4, DEB_CNT=4, STEP_CNT=8, 20 ns clock.
// Key change at a negedge becomes a mode load on the 7th following rising edge.
module tb_led_flow_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] led;
  logic [1:0] mode;

  int n_checks = 0;
  int n_err    = 0;

  led_flow_ctrl #(
    .LED_W    (4),
    .STEP_CNT (8),
    .DEB_CNT  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .led   (led),
    .mode  (mode)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    int         wait_n;
    logic [3:0] led;
    logic [1:0] mode;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [3:0] exp_led, input logic [1:0] exp_mode);
    n_checks++;
    if (led !== exp_led || mode !== exp_mode) begin
      n_err++;
      $display("FAIL %s: got led=%b mode=%0d, expected led=%b mode=%0d at %0t",
               name, led, mode, exp_led, exp_mode, $time);
    end
  endtask

  task automatic step_check(input string name, input logic [3:0] k, input int n,
                            input logic [3:0] exp_led, input logic [1:0] exp_mode);
    key = k;
    repeat (n) @(negedge clk);
    check(name, exp_led, exp_mode);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // key, negedges to wait, expected led, expected mode
    vecs.push_back('{4'b1111,  2, 4'b0000, 2'd0});
    vecs.push_back('{4'b1111, 20, 4'b0000, 2'd0});
    vecs.push_back('{4'b1110,  7, 4'b0001, 2'd1});
    vecs.push_back('{4'b1110,  8, 4'b0010, 2'd1});
    vecs.push_back('{4'b1110,  8, 4'b0100, 2'd1});
    vecs.push_back('{4'b1110,  8, 4'b1000, 2'd1});
    vecs.push_back('{4'b1110,  8, 4'b0001, 2'd1});
    vecs.push_back('{4'b1111,  8, 4'b0010, 2'd1});
    vecs.push_back('{4'b1101,  7, 4'b1000, 2'd2});
    vecs.push_back('{4'b1101,  8, 4'b0100, 2'd2});
    vecs.push_back('{4'b1101,  8, 4'b0010, 2'd2});
    vecs.push_back('{4'b1101,  8, 4'b0001, 2'd2});
    vecs.push_back('{4'b1101,  8, 4'b1000, 2'd2});
    vecs.push_back('{4'b1011,  7, 4'b0001, 2'd3});
    vecs.push_back('{4'b1011,  8, 4'b0010, 2'd3});
    vecs.push_back('{4'b1011,  8, 4'b0100, 2'd3});
    vecs.push_back('{4'b1011,  8, 4'b1000, 2'd3});
    vecs.push_back('{4'b1011,  8, 4'b0100, 2'd3});
    vecs.push_back('{4'b1011,  8, 4'b0010, 2'd3});
    vecs.push_back('{4'b1011,  8, 4'b0001, 2'd3});
    vecs.push_back('{4'b1011,  8, 4'b0010, 2'd3});
    // 3-cycle glitch on key[0] must not leave PING
    vecs.push_back('{4'b1010,  3, 4'b0010, 2'd3});
    vecs.push_back('{4'b1011,  5, 4'b0100, 2'd3});
    vecs.push_back('{4'b1111,  8, 4'b1000, 2'd3});
    // key[0] and key[1] together: SHL wins
    vecs.push_back('{4'b1100,  7, 4'b0001, 2'd1});
    vecs.push_back('{4'b1100,  8, 4'b0010, 2'd1});
    vecs.push_back('{4'b1111,  8, 4'b0100, 2'd1});
    // re-press of current mode restarts pattern and step count
    vecs.push_back('{4'b1110,  7, 4'b0001, 2'd1});
    vecs.push_back('{4'b1110,  5, 4'b0001, 2'd1});
    vecs.push_back('{4'b1110,  3, 4'b0010, 2'd1});

    key   = 4'b1111;
    rst_n = 1'b0;
    #5;
    check("reset_hold", 4'b0000, 2'd0);
    #20;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      key = vecs[i].key;
      repeat (vecs[i].wait_n) @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].led, vecs[i].mode);
    end

    // Asynchronous reset in the middle of a PING step
    step_check("ping_start", 4'b1011,  7, 4'b0001, 2'd3);
    step_check("ping_mid",   4'b1011, 20, 4'b0100, 2'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 4'b0000, 2'd0);
    key = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    step_check("post_reset_quiet", 4'b1111, 30, 4'b0000, 2'd0);

    // key[3] in IDLE does nothing
    step_check("idle_key3",     4'b0111, 20, 4'b0000, 2'd0);
    step_check("idle_key3_rel", 4'b1111,  8, 4'b0000, 2'd0);
    step_check("shr_restart",   4'b1101,  7, 4'b1000, 2'd2);

`ifdef LED_FLOW_PAUSE_EN
    step_check("pause_on",     4'b0111,  7, 4'b1000, 2'd2);
    step_check("pause_hold_a", 4'b1111, 50, 4'b1000, 2'd2);
    step_check("pause_hold_b", 4'b1111, 50, 4'b1000, 2'd2);
    step_check("pause_off",    4'b0111,  7, 4'b1000, 2'd2);
    step_check("resume_p1",    4'b0111,  1, 4'b1000, 2'd2);
    step_check("resume_p2",    4'b0111,  1, 4'b0100, 2'd2);
    step_check("resume_next",  4'b0111,  8, 4'b0010, 2'd2);
`else
    step_check("key3_ign_a",   4'b0111,  7, 4'b1000, 2'd2);
    step_check("key3_ign_b",   4'b0111,  1, 4'b0100, 2'd2);
    step_check("key3_ign_c",   4'b0111,  8, 4'b0010, 2'd2);
    step_check("key3_ign_d",   4'b1111,  8, 4'b0001, 2'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
